bcd_display_scan: RTL and testbench

- Downstream consumer of the multiplier state machine's result.
- Captures its 19-bit, 5-digit BCD result (`bcd`) on the rising edge of `doneSignal`.
- Drives a time-multiplexed 5-digit 7-segment display with leading-zero blanking and an anti-ghosting guard interval.
- Sits between the multiplier and the board display pins.

---
 rtl/bcd_display_scan_pkg.sv | 30 +++
 rtl/bcd_display_scan_if.sv | 16 +
 rtl/bcd_display_scan_bcd_to_seg7.sv | 28 ++
 rtl/bcd_display_scan.sv | 109 ++++++++++
 tb/tb_bcd_display_scan.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_scan_pkg.sv
`timescale 1ns/1ps
// Shared constants for the multiplexed BCD 7-segment display: digit count, widths, segment patterns.
// Patterns are active-high {g,f,e,d,c,b,a}; pin polarity is applied in the top.
package bcd_display_scan_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 19;
  localparam int SEG_W      = 7;
  localparam int DIG_W      = 3;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [DIG_W-1:0] d);
    return NUM_DIGITS'(1) << d;
  endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
`timescale 1ns/1ps
// Result-in / display-out bundle: master is the result producer, slave is the display scanner.
// No handshake: doneSignal is a level whose rising edge marks a new result.
interface bcd_display_scan_if;
  import bcd_display_scan_pkg::*;

  logic                  doneSignal;
  logic [BCD_W-1:0]      bcd;
  seg_t                  seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  shown;

  modport master (output doneSignal, bcd, input seg, an, shown);
  modport slave  (input doneSignal, bcd, output seg, an, shown);

endinterface

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
`timescale 1ns/1ps
// BCD nibble to active-high 7-segment pattern; purely combinational, no backpressure.
// Non-decimal nibbles render as a dash so corrupt results are visible rather than misleading.
module bcd_to_seg7
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
`timescale 1ns/1ps
// Captures a 5-digit BCD result on doneSignal's rising edge and scans it onto a multiplexed display
// with leading-zero blanking and a per-slot anode guard; outputs registered, 1-cycle latency, no backpressure.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV    = 100000,
  parameter int GUARD          = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input logic              clk,
  input logic              rst,
  bcd_display_scan_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam seg_t                  SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = AN_ACTIVE_LOW ? '1 : '0;

  logic                  done_q;
  logic [BCD_W-1:0]      captured_q, captured_d;
  logic                  shown_q, shown_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                    cap_fire;
  logic [4*NUM_DIGITS-1:0] cap_ext;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    zero_acc;
  seg_t                    pat;

  assign cap_fire = bus.doneSignal & ~done_q;
  assign cap_ext  = {{(4*NUM_DIGITS-BCD_W){1'b0}}, captured_q};

  // upper_zero[i]: digits i..top are all zero, i.e. digit i is a leading zero
  always_comb begin
    upper_zero = '0;
    zero_acc   = 1'b1;
    cur_nib    = 4'd0;
    cur_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = cap_ext[4*i +: 4];
    end
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      zero_acc      = zero_acc && (nib[i] == 4'd0);
      upper_zero[i] = zero_acc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == DIG_W'(i)) begin
        cur_nib   = nib[i];
        cur_blank = BLANK_LZ && (i != 0) && upper_zero[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (pat)
  );

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    dig_d      = dig_q;
    if (cnt_q == CNT_W'(REFRESH_DIV-1)) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_W'(NUM_DIGITS-1)) ? '0 : dig_q + 1'b1;
    end
    captured_d = cap_fire ? bus.bcd : captured_q;
    shown_d    = shown_q | cap_fire;
    an_d       = AN_POL;
    seg_d      = SEG_OFF ^ SEG_POL;
    if (int'(cnt_q) >= GUARD) begin
      an_d  = dig_onehot(dig_q) ^ AN_POL;
      seg_d = (cur_blank ? SEG_OFF : pat) ^ SEG_POL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      captured_q <= '0;
      shown_q    <= 1'b0;
      cnt_q      <= '0;
      dig_q      <= '0;
      seg_q      <= SEG_OFF ^ SEG_POL;
      an_q       <= AN_POL;
    end else begin
      done_q     <= bus.doneSignal;
      captured_q <= captured_d;
      shown_q    <= shown_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.shown = shown_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
`timescale 1ns/1ps
// Bench for bcd_display_scan: cycle scoreboard against a reference model plus per-slot digit tables.
module tb_bcd_display_scan;
  import bcd_display_scan_pkg::*;

  localparam int RD = 4;
  localparam int GD = 1;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bcd_display_scan_if bus();

  bcd_display_scan #(
    .REFRESH_DIV    (RD),
    .GUARD          (GD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .BLANK_LZ       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] ref_pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference model of the scan, pushes the expected pin values for each edge
  int          m_cnt, m_dig;
  logic [19:0] m_cap;
  logic        m_done_q, m_shown;
  logic [12:0] sb_q[$];

  always @(posedge clk) begin
    logic [6:0]  e_seg;
    logic [4:0]  e_an;
    logic [3:0]  n;
    logic [12:0] e_all;
    logic [12:0] g_all;
    if (rst) begin
      m_cnt = 0; m_dig = 0; m_cap = '0; m_done_q = 1'b0; m_shown = 1'b0;
      sb_q.delete();
    end else begin
      n = 4'((m_cap >> (4*m_dig)) & 20'hF);
      if (m_cnt < GD) begin
        e_seg = 7'h7F;
        e_an  = 5'h1F;
      end else begin
        e_an = ~(5'b00001 << m_dig);
        if (m_dig != 0 && (m_cap >> (4*m_dig)) == 20'h0) e_seg = 7'h7F;
        else                                             e_seg = ~ref_pat(n);
      end
      if (bus.doneSignal && !m_done_q) begin
        m_cap   = {1'b0, bus.bcd};
        m_shown = 1'b1;
      end
      m_done_q = bus.doneSignal;
      if (m_cnt == RD-1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 5;
      end else begin
        m_cnt++;
      end
      sb_q.push_back({e_seg, e_an, m_shown});
      #1;
      if (!rst && sb_q.size() > 0) begin
        e_all = sb_q.pop_front();
        g_all = {bus.seg, bus.an, bus.shown};
        chk("scoreboard", 32'(g_all), 32'(e_all));
      end
    end
  end

  task automatic pulse(input logic [18:0] v);
    @(negedge clk);
    bus.bcd        = v;
    bus.doneSignal = 1'b1;
    @(negedge clk);
    bus.doneSignal = 1'b0;
  endtask

  // Record the segment pattern seen in each digit's slot over one full scan
  task automatic run_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
    logic [6:0] seen [5];
    logic [6:0] want [5];
    bit         hit  [5];
    want = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) begin
      seen[i] = '0;
      hit[i]  = 1'b0;
    end
    repeat (5*RD + 2) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 5; i++) begin
        if (bus.an == ~(5'b00001 << i)) begin
          seen[i] = bus.seg;
          hit[i]  = 1'b1;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'({hit[i], seen[i]}), 32'({1'b1, want[i]}));
    end
  endtask

  initial begin
    bit found;
    rst            = 1'b1;
    bus.doneSignal = 1'b0;
    bus.bcd        = '0;
    #3;
    chk("rst_seg",   32'(bus.seg),   32'h7F);
    chk("rst_an",    32'(bus.an),    32'h1F);
    chk("rst_shown", 32'(bus.shown), 32'h0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_scan("idle", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    pulse(19'h00006);
    @(negedge clk);
    chk("shown_set", 32'(bus.shown), 32'h1);
    run_scan("six", 7'h02, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    pulse(19'h65025);
    run_scan("m65025", 7'h12, 7'h24, 7'h40, 7'h12, 7'h02);

    @(negedge clk);
    bus.bcd        = 19'h00225;
    bus.doneSignal = 1'b1;
    repeat (10) @(negedge clk);
    bus.bcd = 19'h00999;
    repeat (10) @(negedge clk);
    bus.doneSignal = 1'b0;
    run_scan("held", 7'h12, 7'h24, 7'h24, 7'h7F, 7'h7F);
    pulse(19'h00999);
    run_scan("nine", 7'h10, 7'h10, 7'h10, 7'h7F, 7'h7F);

    pulse(19'h0000A);
    run_scan("dash", 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    pulse(19'h65025);
    run_scan("again", 7'h12, 7'h24, 7'h40, 7'h12, 7'h02);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.an == 5'h17) found = 1'b1;
    end
    chk("wait_dig3", 32'(found), 32'h1);
    chk("dig3_seg", 32'(bus.seg), 32'h12);
    rst = 1'b1;
    #1;
    chk("mid_rst_seg",   32'(bus.seg),   32'h7F);
    chk("mid_rst_an",    32'(bus.an),    32'h1F);
    chk("mid_rst_shown", 32'(bus.shown), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_shown", 32'(bus.shown), 32'h0);
    run_scan("post_rst", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
